// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops plus an iterative shift-add multiplier.
// One output slot; results leave strictly in acceptance order.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_SAR = 4'h8;
  localparam logic [3:0] OP_ROL = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_ADC = 4'hB;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_n;
  logic                 c_reg;
  logic [WIDTH-1:0]     ma;
  logic [2*WIDTH-1:0]   prod, prod_n;
  logic [WIDTH:0]       msum;
  logic [SW-1:0]        cnt;
  logic [SW-1:0]        n;
  logic [SW:0]          rn;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     s_res;
  logic                 s_co, s_ov, c_upd;
  logic                 accept, is_mul, wr_alu, mul_last;

  assign n        = b[SW-1:0];
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL);
  assign wr_alu   = accept && !is_mul;
  assign mul_last = (state == MUL) && (cnt == SW'(WIDTH - 1));

  // One shift-add step: add multiplicand on low bit, shift right
  always_comb begin
    msum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
           + (prod[0] ? {1'b0, ma} : '0);
    prod_n = {msum, prod[WIDTH-1:1]};
  end

  // Single-cycle ALU result and flags
  always_comb begin
    sum   = '0;
    s_res = '0;
    s_co  = 1'b0;
    s_ov  = 1'b0;
    c_upd = 1'b0;
    rn    = (SW+1)'(WIDTH) - {1'b0, n};
    unique case (opcode)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, (opcode == OP_ADC) ? c_reg : carry_in};
        s_res = sum[WIDTH-1:0];
        s_co  = sum[WIDTH];
        s_ov  = (a[WIDTH-1] == b[WIDTH-1])
              && (s_res[WIDTH-1] != a[WIDTH-1]);
        c_upd = 1'b1;
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        s_res = sum[WIDTH-1:0];
        s_co  = sum[WIDTH];
        s_ov  = (a[WIDTH-1] != b[WIDTH-1])
              && (s_res[WIDTH-1] != a[WIDTH-1]);
        c_upd = 1'b1;
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_NOT: s_res = ~a;
      OP_SHL: begin
        {s_co, s_res} = {1'b0, a} << n;
        c_upd = 1'b1;
      end
      OP_SHR: begin
        {s_res, s_co} = {a, 1'b0} >> n;
        c_upd = 1'b1;
      end
      OP_SAR: begin
        {s_res, s_co} = $signed({a, 1'b0}) >>> n;
        c_upd = 1'b1;
      end
      OP_ROL: begin
        s_res = (a << n) | (a >> rn);
        s_co  = (n != '0) && s_res[0];
        c_upd = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_n = MUL;
      MUL:  if (mul_last)         state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state == MUL);
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  // Stored carry for ADC chaining
  always_ff @(posedge clk) begin
    if (reset)                c_reg <= 1'b0;
    else if (accept && c_upd) c_reg <= s_co;
  end

  // Multiplier operand latch and iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      ma   <= '0;
      prod <= '0;
      cnt  <= '0;
    end else if (accept && is_mul) begin
      ma   <= a;
      prod <= {{WIDTH{1'b0}}, b};
      cnt  <= '0;
    end else if (state == MUL) begin
      prod <= prod_n;
      cnt  <= cnt + SW'(1);
    end
  end

  // Output slot: written by ALU or final multiply step
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_alu) begin
        result    <= s_res;
        result_hi <= '0;
        carry_out <= s_co;
        zero      <= (s_res == '0);
        negative  <= s_res[WIDTH-1];
        overflow  <= s_ov;
      end else if (mul_last) begin
        result    <= prod_n[WIDTH-1:0];
        result_hi <= prod_n[2*WIDTH-1:WIDTH];
        carry_out <= 1'b0;
        zero      <= (prod_n == '0);
        negative  <= prod_n[2*WIDTH-1];
        overflow  <= (prod_n[2*WIDTH-1:WIDTH] != '0);
      end
      if (wr_alu || mul_last) out_valid <= 1'b1;
      else if (out_ready)     out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit combinational ALU. It accepts one operation at a time over a valid/ready input channel and returns a registered result with flags over a valid/ready output channel. It adds variable shift amounts, arithmetic shift, rotate, a carry-chained add (ADC) using a stored carry flag, and a multi-cycle unsigned shift-add multiplier. It sits between the operand/opcode issue stage and the writeback stage of the datapath.

## Interface
- WIDTH, 8: operand/result width; ≥4, power of two. SW = $clog2(WIDTH) is derived.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- In_valid  in  1  operation offered.
- In_ready  out  1  block can accept; transfer occurs when In_valid && In_ready.
- A, B  in  WIDTH each  operands.
- Opcode  in  4  operation select.
- Carry_in  in  1  carry into ADD only.
- Out_valid  out  1  result register holds an undelivered result.
- Out_ready  in  1  consumer takes result; transfer occurs when Out_valid && Out_ready.
- Result  out  WIDTH  result; low half for MUL.
- Result_hi  out  WIDTH  MUL high half; 0 for every other op.
- Carry_out, Zero, Negative, Overflow  out  1 each  flags of the current Result.
- Busy  out  1  multiply in progress.

## Operation
- Opcodes:
  - 0000 ADD: A+B+Carry_in.
  - 0001 SUB: A−B, Carry_in ignored, Carry_out = borrow (A<B unsigned).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A.
  - 0110 SHL, 0111 SHR (logical), 1000 SAR, 1001 ROL, each by n = B[SW-1:0]; upper B bits are ignored.
  - 1010 MUL: unsigned A×B, 2·WIDTH-bit product.
  - 1011 ADC: A+B+C_reg.
  - 1100–1111 reserved: Result 0, Zero 1, all other flags 0.
- Flags:
  - Carry_out:
    - ADD/ADC: bit WIDTH of the sum.
    - SHL by n: A[WIDTH−n].
    - SHR/SAR by n: A[n−1].
    - ROL: Result[0].
    - Any shift with n=0: 0.
    - Logic ops and MUL: 0.
  - Overflow:
    - ADD/ADC/SUB: signed overflow.
    - MUL: Result_hi≠0.
    - Otherwise: 0.
  - Zero: Result==0; for MUL, the full product is 0.
  - Negative: Result[WIDTH−1]; for MUL, Result_hi[WIDTH−1].
- Stored carry C_reg:
  - Loaded at the accept edge with Carry_out of ADD/SUB/ADC/SHL/SHR/SAR/ROL.
  - Unchanged by logic ops, MUL and reserved opcodes.
  - An ADC accepted on the very next edge therefore sees the updated value.
- FSM:
  - IDLE: accepts an op. A single-cycle op is computed combinationally and written to the output register at the accept edge. MUL latches A, B, clears the accumulator and goes to MUL.
  - MUL: one shift-add iteration per cycle for WIDTH iterations. The last iteration writes the output register and returns to IDLE. Busy=1 only in MUL.
- In_ready = (state==IDLE) && (!Out_valid || Out_ready). The combinational Out_ready→In_ready path is permitted.
- Output register:
  - Set on write.
  - Cleared on output transfer with no simultaneous write.
  - On simultaneous transfer and write it holds the new result and Out_valid stays 1.
- Result and flags are stable while Out_valid && !Out_ready.
- Ops complete and are delivered strictly in acceptance order. There is one output slot and no reordering.

## Timing
- Reset sets: state IDLE, Out_valid 0, Result 0, Result_hi 0, all flags 0, C_reg 0, Busy 0.
  - In_ready is 1 in the first cycle after Reset.
- Single-cycle op accepted at edge t: Out_valid=1 after edge t; sustained throughput is 1 op/cycle with Out_ready held 1.
- MUL accepted at edge t: Busy=1 and In_ready=0 after edge t through edge t+WIDTH−1. Result is written and Out_valid=1 after edge t+WIDTH. In_ready returns per the rule above.
- Reset asserted during MUL: aborts with no result emitted; the post-reset state is as above.
- Reset overrides a simultaneous input or output transfer.
- Out_ready low with a pending result: no new op is accepted, and Result/flags/Out_valid hold.

## Test plan
- ADD FF+01, Carry_in 0 → Result 00, Carry_out 1, Zero 1, Overflow 0, Out_valid one cycle after accept. Then ADC 00+00 → Result 01, Carry_out 0.
- SUB 10−55 → Result BB, Carry_out 1, Negative 1, Overflow 0. Then SUB 80−01 → Result 7F, Overflow 1, Carry_out 0.
- MUL FF×FF → Result 01, Result_hi FE, Overflow 1, Negative 1. Out_valid rises exactly 8 edges after accept; In_ready=0 and Busy=1 throughout.
- Shifts:
  - SHL AA by 1 → 54, Carry_out 1.
  - SAR 80 by 3 → F0, Carry_out 0.
  - ROL 81 by 4 → 18.
  - SHR AA with B=08 (n=0) → AA, Carry_out 0.
- Backpressure: Out_ready=0 with XOR 55^FF pending (Result AA). A second op (AND 55&0F) is held, In_ready=0, and Result stays AA. Raise Out_ready: AA is delivered, then 05 the next cycle, in order.
- Reset asserted during the 4th MUL cycle → Out_valid 0, Busy 0, In_ready 1 after that edge, and no MUL result appears. A following ADC 01+01 → 02 (C_reg cleared).
